// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB) with ack time-out and retire counter.
// Latency: ALU 4, LOAD 5, STORE 4, BRANCH 3, LINK 4 cycles with zero-wait acks; each missing ack adds a cycle.
module mc_ctrl #(
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  opcode,
    input  logic [5:0]  func,
    input  logic        imem_ack,
    input  logic        dmem_ack,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        IRWr,
    output logic        PCWr,
    output logic        RFWr_en,
    output logic [2:0]  state,
    output logic        illegal,
    output logic        timeout_err,
    output logic [31:0] instret
);
    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] OP_JAL    = 6'b000011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BLEZ   = 6'b000110;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;
    localparam logic [5:0] OP_ADDI   = 6'b001000;
    localparam logic [5:0] OP_ADDIU  = 6'b001001;
    localparam logic [5:0] OP_SLTI   = 6'b001010;
    localparam logic [5:0] OP_SLTIU  = 6'b001011;
    localparam logic [5:0] OP_ANDI   = 6'b001100;
    localparam logic [5:0] OP_ORI    = 6'b001101;
    localparam logic [5:0] OP_XORI   = 6'b001110;
    localparam logic [5:0] OP_LUI    = 6'b001111;
    localparam logic [5:0] OP_LB     = 6'b100000;
    localparam logic [5:0] OP_LH     = 6'b100001;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_LBU    = 6'b100100;
    localparam logic [5:0] OP_LHU    = 6'b100101;
    localparam logic [5:0] OP_SB     = 6'b101000;
    localparam logic [5:0] OP_SH     = 6'b101001;
    localparam logic [5:0] OP_SW     = 6'b101011;

    localparam logic [5:0] F_SLL  = 6'b000000;
    localparam logic [5:0] F_SRL  = 6'b000010;
    localparam logic [5:0] F_SRA  = 6'b000011;
    localparam logic [5:0] F_SLLV = 6'b000100;
    localparam logic [5:0] F_SRLV = 6'b000110;
    localparam logic [5:0] F_SRAV = 6'b000111;
    localparam logic [5:0] F_JR   = 6'b001000;
    localparam logic [5:0] F_JALR = 6'b001001;
    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_ADDU = 6'b100001;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_SUBU = 6'b100011;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_XOR  = 6'b100110;
    localparam logic [5:0] F_NOR  = 6'b100111;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_SLTU = 6'b101011;

    localparam logic [7:0] TMO = 8'(ACK_TIMEOUT);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        C_ALU, C_LOAD, C_STORE, C_BRANCH, C_LINK, C_ILL
    } cls_t;

    state_t     st;
    cls_t       cls;
    cls_t       dec_cls;
    logic [7:0] wcnt;
    logic       expired;

    always_comb begin
        dec_cls = C_ILL;
        case (opcode)
            OP_RTYPE: begin
                case (func)
                    F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV,
                    F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR,
                    F_XOR, F_NOR, F_SLT, F_SLTU: dec_cls = C_ALU;
                    F_JR:    dec_cls = C_BRANCH;
                    F_JALR:  dec_cls = C_LINK;
                    default: dec_cls = C_ILL;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI,
            OP_LUI, OP_SLTI, OP_SLTIU:                   dec_cls = C_ALU;
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU:         dec_cls = C_LOAD;
            OP_SB, OP_SH, OP_SW:                         dec_cls = C_STORE;
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ,
            OP_REGIMM, OP_J:                             dec_cls = C_BRANCH;
            OP_JAL:                                      dec_cls = C_LINK;
            default:                                     dec_cls = C_ILL;
        endcase
    end

    // Once the counter sits at TMO the wait is over: the request is dropped for one cycle and acks are ignored.
    assign expired = (wcnt == TMO);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st          <= S_FETCH;
            cls         <= C_ALU;
            wcnt        <= 8'd0;
            timeout_err <= 1'b0;
            instret     <= 32'd0;
        end else begin
            wcnt <= 8'd0;
            case (st)
                S_FETCH: begin
                    if (!expired) begin
                        if (imem_ack) begin
                            st <= S_DECODE;
                        end else begin
                            wcnt <= wcnt + 8'd1;
                            if (wcnt == TMO - 8'd1)
                                timeout_err <= 1'b1;
                        end
                    end
                end
                S_DECODE: begin
                    cls <= dec_cls;
                    st  <= (dec_cls == C_ILL) ? S_FETCH : S_EXEC;
                end
                S_EXEC: begin
                    case (cls)
                        C_ALU, C_LINK:   st <= S_WB;
                        C_LOAD, C_STORE: st <= S_MEM;
                        C_BRANCH: begin
                            st      <= S_FETCH;
                            instret <= instret + 32'd1;
                        end
                        default:         st <= S_FETCH;
                    endcase
                end
                S_MEM: begin
                    if (expired) begin
                        st <= S_FETCH;
                    end else if (dmem_ack) begin
                        if (cls == C_STORE) begin
                            st      <= S_FETCH;
                            instret <= instret + 32'd1;
                        end else begin
                            st <= S_WB;
                        end
                    end else begin
                        wcnt <= wcnt + 8'd1;
                        if (wcnt == TMO - 8'd1)
                            timeout_err <= 1'b1;
                    end
                end
                S_WB: begin
                    st      <= S_FETCH;
                    instret <= instret + 32'd1;
                end
                default: st <= S_FETCH;
            endcase
        end
    end

    // Strobes are gated by rst so they fall immediately, not at the next edge.
    assign state    = st;
    assign imem_req = !rst && (st == S_FETCH) && !expired;
    assign dmem_req = !rst && (st == S_MEM) && !expired;
    assign IRWr     = imem_req && imem_ack;
    assign PCWr     = IRWr || (!rst && (st == S_EXEC) && (cls == C_BRANCH || cls == C_LINK));
    assign RFWr_en  = !rst && (st == S_WB);
    assign illegal  = !rst && (st == S_DECODE) && (dec_cls == C_ILL);

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: decode vector table, hand-written wait/time-out/reset sequences and a random instruction stream.
module tb_mc_ctrl;
    localparam int T = 15;
    localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2, K_BR = 3, K_LINK = 4, K_ILL = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  opcode = 6'd0;
    logic [5:0]  func = 6'd0;
    logic        imem_ack = 1'b0;
    logic        dmem_ack = 1'b0;
    logic        imem_req, dmem_req, IRWr, PCWr, RFWr_en, illegal, timeout_err;
    logic [2:0]  state;
    logic [31:0] instret;

    mc_ctrl #(.ACK_TIMEOUT(T)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .func(func),
        .imem_ack(imem_ack), .dmem_ack(dmem_ack),
        .imem_req(imem_req), .dmem_req(dmem_req), .IRWr(IRWr), .PCWr(PCWr),
        .RFWr_en(RFWr_en), .state(state), .illegal(illegal),
        .timeout_err(timeout_err), .instret(instret)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc, ireq, dreq, ir, pc, rf, ill;
    } obs_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        int cyc, pc, rf, ill, ret;
    } vec_t;

    int tests = 0;
    int fails = 0;
    int unsigned exp_ret = 0;

    logic [5:0] alu_op   [8]  = '{6'h08, 6'h09, 6'h0c, 6'h0d, 6'h0e, 6'h0f, 6'h0a, 6'h0b};
    logic [5:0] alu_fn   [16] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                  6'h2a, 6'h2b, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};
    logic [5:0] load_op  [5]  = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
    logic [5:0] store_op [3]  = '{6'h28, 6'h29, 6'h2b};
    logic [5:0] br_op    [6]  = '{6'h04, 6'h05, 6'h06, 6'h07, 6'h01, 6'h02};
    int         seq_exp  [5]  = '{0, 1, 2, 4, 0};
    vec_t       vt       [12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'h00) begin
            if (fn == 6'h08) return K_BR;
            if (fn == 6'h09) return K_LINK;
            foreach (alu_fn[i]) if (alu_fn[i] == fn) return K_ALU;
            return K_ILL;
        end
        if (op == 6'h03) return K_LINK;
        foreach (alu_op[i])   if (alu_op[i] == op)   return K_ALU;
        foreach (load_op[i])  if (load_op[i] == op)  return K_LOAD;
        foreach (store_op[i]) if (store_op[i] == op) return K_STORE;
        foreach (br_op[i])    if (br_op[i] == op)    return K_BR;
        return K_ILL;
    endfunction

    // Called at posedge+1 of a fresh FETCH cycle; returns at posedge+1 of the next instruction's FETCH.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int di, input int dd,
                             input bit hold, input bit noise, output obs_t o);
        bit prev;
        o = '{default: 0};
        prev = 1'b1;
        opcode = op;
        func = fn;
        while (o.cyc < 4 * T + 20) begin
            if (o.cyc > 0 && imem_req && !prev) break;
            if (hold) begin
                imem_ack = 1'b1;
                dmem_ack = 1'b1;
            end else begin
                imem_ack = imem_req ? (o.ireq == di) : (noise && $urandom_range(1) == 1);
                dmem_ack = dmem_req ? (o.dreq == dd) : (noise && $urandom_range(1) == 1);
            end
            #1;
            o.ireq += int'(imem_req);
            o.dreq += int'(dmem_req);
            o.ir   += int'(IRWr);
            o.pc   += int'(PCWr);
            o.rf   += int'(RFWr_en);
            o.ill  += int'(illegal);
            prev = imem_req;
            o.cyc++;
            @(posedge clk);
            #1;
        end
    endtask

    // Expectations from the per-class latency plus one extra cycle per missing ack.
    task automatic check_obs(input string tag, input int k, input int di, input int dd, input obs_t o);
        int cyc;
        case (k)
            K_ILL:   cyc = di + 2;
            K_ALU:   cyc = di + 4;
            K_LOAD:  cyc = di + dd + 5;
            K_STORE: cyc = di + dd + 4;
            K_BR:    cyc = di + 3;
            default: cyc = di + 4;
        endcase
        if (k != K_ILL) exp_ret++;
        chk({tag, " cycles"}, o.cyc, cyc);
        chk({tag, " imem_req cycles"}, o.ireq, di + 1);
        chk({tag, " dmem_req cycles"}, o.dreq, (k == K_LOAD || k == K_STORE) ? dd + 1 : 0);
        chk({tag, " IRWr"}, o.ir, 1);
        chk({tag, " PCWr"}, o.pc, (k == K_BR || k == K_LINK) ? 2 : 1);
        chk({tag, " RFWr_en"}, o.rf, (k == K_ALU || k == K_LOAD || k == K_LINK) ? 1 : 0);
        chk({tag, " illegal"}, o.ill, (k == K_ILL) ? 1 : 0);
        chk({tag, " instret"}, instret, exp_ret);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t o;
        int k, di, dd, n;
        logic [5:0] op, fn;

        vt[0]  = '{6'h08, 6'h00, 4, 1, 1, 0, 1};  // ADDI
        vt[1]  = '{6'h23, 6'h00, 5, 1, 1, 0, 1};  // LW
        vt[2]  = '{6'h2b, 6'h00, 4, 1, 0, 0, 1};  // SW
        vt[3]  = '{6'h04, 6'h00, 3, 2, 0, 0, 1};  // BEQ
        vt[4]  = '{6'h03, 6'h00, 4, 2, 1, 0, 1};  // JAL
        vt[5]  = '{6'h00, 6'h20, 4, 1, 1, 0, 1};  // ADD
        vt[6]  = '{6'h00, 6'h08, 3, 2, 0, 0, 1};  // JR
        vt[7]  = '{6'h00, 6'h09, 4, 2, 1, 0, 1};  // JALR
        vt[8]  = '{6'h3f, 6'h15, 2, 1, 0, 1, 0};  // unknown opcode
        vt[9]  = '{6'h00, 6'h3f, 2, 1, 0, 1, 0};  // R_type, unlisted func
        vt[10] = '{6'h01, 6'h00, 3, 2, 0, 0, 1};  // REGIMM
        vt[11] = '{6'h0f, 6'h00, 4, 1, 1, 0, 1};  // LUI

        #2;
        chk("reset state", state, 0);
        chk("reset imem_req", imem_req, 0);
        chk("reset strobes", {dmem_req, IRWr, PCWr, RFWr_en, illegal}, 0);
        chk("reset instret", instret, 0);
        chk("reset timeout_err", timeout_err, 0);
        #10 rst = 1'b0;
        @(posedge clk);
        #1;

        // ADDI with both acks held high walks FETCH, DECODE, EXEC, WB, FETCH.
        opcode = 6'h08;
        imem_ack = 1'b1;
        dmem_ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("addi state seq", state, seq_exp[i]);
            chk("addi RFWr_en seq", RFWr_en, (i == 3) ? 1 : 0);
            if (i < 4) begin
                @(posedge clk);
                #1;
            end
        end
        exp_ret++;
        chk("addi instret", instret, exp_ret);

        for (int i = 0; i < 12; i++) begin
            run_instr(vt[i].op, vt[i].fn, 0, 0, 1'b1, 1'b0, o);
            exp_ret += vt[i].ret;
            chk($sformatf("vec%0d cycles", i), o.cyc, vt[i].cyc);
            chk($sformatf("vec%0d PCWr", i), o.pc, vt[i].pc);
            chk($sformatf("vec%0d RFWr_en", i), o.rf, vt[i].rf);
            chk($sformatf("vec%0d illegal", i), o.ill, vt[i].ill);
            chk($sformatf("vec%0d instret", i), instret, exp_ret);
        end

        run_instr(6'h23, 6'h00, 0, 3, 1'b0, 1'b0, o);
        check_obs("lw dmem wait 3", K_LOAD, 0, 3, o);
        run_instr(6'h08, 6'h00, T - 1, 0, 1'b0, 1'b0, o);
        check_obs("imem ack on last cycle", K_ALU, T - 1, 0, o);
        run_instr(6'h23, 6'h00, 0, T - 1, 1'b0, 1'b0, o);
        check_obs("dmem ack on last cycle", K_LOAD, 0, T - 1, o);
        chk("no timeout at limit", timeout_err, 0);

        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(9) == 0) begin
                op = 6'($urandom);
                fn = 6'($urandom);
            end else begin
                fn = 6'($urandom);
                case ($urandom_range(5))
                    0: begin op = 6'h00; fn = alu_fn[$urandom_range(15)]; end
                    1: op = alu_op[$urandom_range(7)];
                    2: op = load_op[$urandom_range(4)];
                    3: op = store_op[$urandom_range(2)];
                    4: op = br_op[$urandom_range(5)];
                    default: begin op = 6'h00; fn = ($urandom_range(1) == 1) ? 6'h09 : 6'h08; end
                endcase
            end
            k  = classify(op, fn);
            di = ($urandom_range(3) == 0) ? $urandom_range(T - 1) : $urandom_range(2);
            dd = ($urandom_range(3) == 0) ? $urandom_range(T - 1) : $urandom_range(2);
            run_instr(op, fn, di, dd, 1'b0, 1'b1, o);
            check_obs($sformatf("rand%0d", i), k, di, dd, o);
        end
        chk("random timeout_err", timeout_err, 0);

        // Instruction fetch never acknowledged.
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        n = 0;
        while (imem_req && n < 3 * T) begin
            n++;
            @(posedge clk);
            #1;
        end
        chk("fetch timeout req cycles", n, T);
        chk("fetch timeout_err", timeout_err, 1);
        chk("fetch timeout state", state, 0);
        chk("fetch timeout instret", instret, exp_ret);
        @(posedge clk);
        #1;
        chk("fetch timeout reassert", imem_req, 1);

        // Store whose data access never completes.
        run_instr(6'h2b, 6'h00, 0, 999, 1'b0, 1'b0, o);
        chk("mem timeout cycles", o.cyc, T + 4);
        chk("mem timeout dmem_req cycles", o.dreq, T);
        chk("mem timeout instret", instret, exp_ret);
        chk("mem timeout_err sticky", timeout_err, 1);

        // Reset in the middle of a store's MEM phase.
        opcode = 6'h2b;
        imem_ack = 1'b1;
        dmem_ack = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("sw in mem state", state, 3);
        chk("sw dmem_req", dmem_req, 1);
        #2 rst = 1'b1;
        #1;
        chk("async rst state", state, 0);
        chk("async rst strobes", {imem_req, dmem_req, IRWr, PCWr, RFWr_en, illegal}, 0);
        chk("async rst instret", instret, 0);
        chk("async rst timeout_err", timeout_err, 0);
        @(negedge clk);
        chk("rst held imem_req", imem_req, 0);
        #2 rst = 1'b0;
        #1;
        chk("post rst imem_req", imem_req, 1);
        chk("post rst state", state, 0);
        @(posedge clk);
        #1;
        chk("post rst first fetch", state, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
